// File: rtl/axis_in_buffer_pkg.sv
// Shared defaults and FSM state encoding for the AXI4-Stream input frame buffer.
package axis_in_buffer_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 800;
  localparam int unsigned PTR_W_DEF  = 10;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FILL  = 2'd1;
  localparam state_t DRAIN = 2'd2;

endpackage

// File: rtl/axis_in_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with read enable.
module axis_in_buffer_sdp_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 800,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata holds its value when re is low, so it can act as a stallable pipeline stage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_in_buffer.sv
// Single-buffer AXI4-Stream frame capture: fill one frame into RAM, then replay it downstream.
module axis_in_buffer
  import axis_in_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned PTR_W  = PTR_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_tvalid,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tstrb,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic [PTR_W-1:0]    frame_len,
  output logic                frame_done,
  output logic                err_len
);

  state_t            state_q;
  logic              tready_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, frame_len_q;
  logic              ram_vld_q, ram_last_q;
  logic [DATA_W-1:0] ram_rdata, out_data_q;
  logic              out_valid_q, out_last_q, frame_done_q, err_len_q;

  logic wr_acc, wr_end, rd_en, out_load, out_fire;
  logic unused_strb;

  assign unused_strb = ^s_axis_tstrb;

  always_comb begin
    wr_acc   = (state_q == FILL) && tready_q && s_axis_tvalid;
    wr_end   = wr_acc && (s_axis_tlast || (wr_ptr_q == PTR_W'(DEPTH - 1)));
    out_fire = out_valid_q && out_ready;
    out_load = ram_vld_q && (!out_valid_q || out_ready);
    // RAM output is a second pipeline stage; refill it whenever it is empty or being drained.
    rd_en    = (state_q == DRAIN) && (rd_ptr_q < frame_len_q) && (!ram_vld_q || out_load);
  end

  axis_in_buffer_sdp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(s_axis_tdata),
    .re   (rd_en),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      tready_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_len_q  <= '0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      frame_done_q <= out_fire && out_last_q;
      case (state_q)
        IDLE: begin
          tready_q <= 1'b1;
          state_q  <= FILL;
        end
        FILL: begin
          if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (wr_end) begin
            frame_len_q <= wr_ptr_q + PTR_W'(1);
            tready_q    <= 1'b0;
            state_q     <= DRAIN;
            if (!s_axis_tlast) err_len_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (rd_en) begin
            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            ram_vld_q  <= 1'b1;
            ram_last_q <= (rd_ptr_q == frame_len_q - PTR_W'(1));
          end else if (out_load) begin
            ram_vld_q <= 1'b0;
          end

          if (out_load) begin
            out_data_q  <= ram_rdata;
            out_valid_q <= 1'b1;
            out_last_q  <= ram_last_q;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end

          if (out_fire && out_last_q) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign frame_len     = frame_len_q;
  assign frame_done    = frame_done_q;
  assign err_len       = err_len_q;

endmodule

// File: tb/tb_axis_in_buffer.sv
// Bench for axis_in_buffer: frame scenarios from a table, checked against a queue-based model.
module tb_axis_in_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 800;
  localparam int unsigned PTR_W  = 10;

  logic                clk = 1'b0;
  logic                rstn;
  logic                s_axis_tvalid;
  logic [DATA_W-1:0]   s_axis_tdata;
  logic [DATA_W/8-1:0] s_axis_tstrb;
  logic                s_axis_tlast;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;
  logic [PTR_W-1:0]    frame_len;
  logic                frame_done;
  logic                err_len;

  always #5 clk = ~clk;

  axis_in_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tstrb (s_axis_tstrb),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .frame_len    (frame_len),
    .frame_done   (frame_done),
    .err_len      (err_len)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  typedef struct {
    int          n;
    bit          tlast;
    bit          incr;
    logic [31:0] base;
    int          ready_pct;
    int          exp_len;
    bit          exp_err;
  } vec_t;

  word_t dma_q[$];
  logic  vld_cur   = 1'b0;
  logic  err_model = 1'b0;
  int    total     = 0;
  int    bad       = 0;
  vec_t  tbl[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic enqueue(input int n, input bit tlast, input bit incr, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      word_t w;
      w.data = incr ? base + 32'(i) : $urandom;
      w.last = tlast && (i == n - 1);
      dma_q.push_back(w);
    end
  endtask

  // Expected frame = queued DMA words up to the first tlast, or DEPTH words if none comes first.
  task automatic run_frame(input string name, input int ready_pct, input int abort_at);
    word_t exp_q[$];
    bit    trunc = 0, done = 0, aborted = 0, draining = 0, prev_stall = 0, seen_vld = 0;
    int    exp_n, in_cnt = 0, out_cnt = 0, iter = 0;
    int    acc_iter = 0, first_vld_iter = 0, fire_iter = 0, done_iter = 0;
    int    data_err = 0, last_err = 0, hold_err = 0, tready_err = 0, gap_err = 0, early_done = 0;
    int    vpct;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_last = 1'b0;

    for (int i = 0; i < dma_q.size(); i++) begin
      exp_q.push_back(dma_q[i]);
      if (dma_q[i].last) break;
      if (exp_q.size() == DEPTH) begin
        trunc = 1;
        break;
      end
    end
    exp_n = exp_q.size();
    vpct  = (ready_pct < 100) ? 80 : 100;

    while (!done && !aborted && iter < 20000) begin
      @(negedge clk);
      if (frame_done) begin
        if (out_cnt < exp_n) early_done++;
        else begin
          done      = 1;
          done_iter = iter;
        end
      end
      if (out_last && !out_valid) last_err++;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) hold_err++;
      if (draining && s_axis_tready) tready_err++;
      if (seen_vld && !out_valid && out_cnt < exp_n) gap_err++;
      if (out_valid && !seen_vld) begin
        seen_vld       = 1;
        first_vld_iter = iter;
      end
      if (!done) begin
        if (!vld_cur && dma_q.size() > 0 && $urandom_range(99) < vpct) vld_cur = 1'b1;
        s_axis_tvalid = vld_cur;
        s_axis_tdata  = vld_cur ? dma_q[0].data : '0;
        s_axis_tlast  = vld_cur ? dma_q[0].last : 1'b0;
        out_ready     = ($urandom_range(99) < ready_pct);
        if (vld_cur && s_axis_tready) begin
          void'(dma_q.pop_front());
          vld_cur = 1'b0;
          in_cnt++;
          if (in_cnt == exp_n) begin
            draining = 1;
            acc_iter = iter;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && out_ready) begin
          if (out_cnt < exp_n) begin
            if (out_data !== exp_q[out_cnt].data) data_err++;
            if (out_last !== (out_cnt == exp_n - 1)) last_err++;
          end else begin
            data_err++;
          end
          out_cnt++;
          fire_iter = iter;
          if (abort_at > 0 && out_cnt == abort_at) aborted = 1;
        end
      end
      iter++;
    end

    if (aborted) return;
    check({name, " completed"}, 32'(done), 32'd1);
    check({name, " word count"}, out_cnt, exp_n);
    check({name, " data errors"}, data_err, 0);
    check({name, " last errors"}, last_err, 0);
    check({name, " stall hold errors"}, hold_err, 0);
    check({name, " tready in drain"}, tready_err, 0);
    check({name, " early done"}, early_done, 0);
    check({name, " done after final accept"}, done_iter - fire_iter, 1);
    // Sampled on negedges: valid seen 3 samples after final accept = 2 cycles after that edge.
    check({name, " first valid latency"}, first_vld_iter - acc_iter, 3);
    if (ready_pct == 100) check({name, " valid gaps"}, gap_err, 0);
    err_model = err_model | trunc;
    check({name, " err_len model"}, 32'(err_len), 32'(err_model));
  endtask

  initial begin
    tbl[0] = '{800, 1'b1, 1'b0, 32'h0,        100, 800, 1'b0};
    tbl[1] = '{5,   1'b1, 1'b1, 32'hA0,       100, 5,   1'b0};
    tbl[2] = '{1,   1'b1, 1'b1, 32'hDEADBEEF, 100, 1,   1'b0};
    tbl[3] = '{10,  1'b1, 1'b0, 32'h0,        50,  10,  1'b0};
    tbl[4] = '{801, 1'b0, 1'b1, 32'h1000,     100, 800, 1'b1};
    tbl[5] = '{3,   1'b1, 1'b1, 32'h5000,     70,  4,   1'b1};
    tbl[6] = '{37,  1'b1, 1'b0, 32'h0,        70,  37,  1'b1};

    rstn          = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '1;
    s_axis_tlast  = 1'b0;
    out_ready     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tready", 32'(s_axis_tready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset frame_len", 32'(frame_len), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset err_len", 32'(err_len), 32'd0);
    rstn = 1'b1;

    for (int t = 0; t < 7; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      enqueue(tbl[t].n, tbl[t].tlast, tbl[t].incr, tbl[t].base);
      run_frame(nm, tbl[t].ready_pct, 0);
      check({nm, " frame_len"}, 32'(frame_len), 32'(tbl[t].exp_len));
      check({nm, " err_len"}, 32'(err_len), 32'(tbl[t].exp_err));
    end

    // Reset during drain after the third output word.
    enqueue(20, 1'b1, 1'b0, 32'h0);
    run_frame("rst_pre", 100, 3);
    @(negedge clk);
    rstn          = 1'b0;
    vld_cur       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    dma_q.delete();
    @(negedge clk);
    check("mid reset tready", 32'(s_axis_tready), 32'd0);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_last", 32'(out_last), 32'd0);
    check("mid reset out_data", out_data, 32'd0);
    check("mid reset frame_len", 32'(frame_len), 32'd0);
    check("mid reset frame_done", 32'(frame_done), 32'd0);
    check("mid reset err_len", 32'(err_len), 32'd0);
    rstn      = 1'b1;
    err_model = 1'b0;
    enqueue(6, 1'b1, 1'b1, 32'h7700);
    run_frame("post_rst", 60, 0);
    check("post_rst frame_len", 32'(frame_len), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
